// File: rtl/seg7_msg_sequencer.sv
// rtl/seg7_msg_sequencer.sv - steps a 16-entry glyph memory onto a seven-segment digit
// with programmable dwell, optional blanking gap, pause and single-step.
module seg7_msg_sequencer #(
  parameter int DWELL_W = 24,
  parameter int GAP_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [3:0]         wr_addr,
  input  logic [3:0]         wr_data,
  input  logic [3:0]         msg_last,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [GAP_W-1:0]   gap_cyc,
  input  logic               loop,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               step,
  output logic [3:0]         code,
  output logic               blank,
  output logic [3:0]         index,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

  state_t             r_state;
  logic [3:0]         r_mem [16];
  logic [3:0]         r_index;
  logic [3:0]         r_last;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_dcnt;
  logic [GAP_W-1:0]   r_gap;
  logic [GAP_W-1:0]   r_gcnt;
  logic               r_blank;
  logic               r_busy;
  logic               r_done;

  logic       w_more;
  logic [3:0] w_next_index;
  logic       w_adv;
  logic       w_fin;
  logic       w_to_gap;
  logic       w_dinc;
  logic       w_ginc;

  // "More glyphs to show" is judged on the glyph currently held, so a step
  // or expiry on the last glyph with loop=0 completes the message.
  assign w_more       = (r_index < r_last) | loop;
  assign w_next_index = (r_index == r_last) ? 4'd0 : r_index + 4'd1;

  always_comb begin
    w_adv    = 1'b0;
    w_fin    = 1'b0;
    w_to_gap = 1'b0;
    w_dinc   = 1'b0;
    w_ginc   = 1'b0;
    case (r_state)
      S_SHOW: begin
        if (pause) begin
          if (step) begin
            w_adv = w_more;
            w_fin = !w_more;
          end
        end else if (r_dcnt == r_dwell) begin
          if (w_more) begin
            w_to_gap = (r_gap != '0);
            w_adv    = (r_gap == '0);
          end else begin
            w_fin = 1'b1;
          end
        end else begin
          w_dinc = 1'b1;
        end
      end
      S_GAP: begin
        if (pause) begin
          if (step) begin
            w_adv = w_more;
            w_fin = !w_more;
          end
        end else if (r_gcnt == r_gap) begin
          w_adv = 1'b1;
        end else begin
          w_ginc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= 4'd0;
      r_state <= S_IDLE;
      r_index <= 4'd0;
      r_last  <= 4'd0;
      r_dwell <= '0;
      r_dcnt  <= '0;
      r_gap   <= '0;
      r_gcnt  <= '0;
      r_blank <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (wr_en) r_mem[wr_addr] <= wr_data;

      if (stop) begin
        r_state <= S_IDLE;
        r_index <= 4'd0;
        r_dcnt  <= '0;
        r_gcnt  <= '0;
        r_blank <= 1'b1;
        r_busy  <= 1'b0;
      end else if (start) begin
        r_last  <= msg_last;
        r_dwell <= dwell;
        r_gap   <= gap_cyc;
        r_state <= S_SHOW;
        r_index <= 4'd0;
        r_dcnt  <= '0;
        r_gcnt  <= '0;
        r_blank <= 1'b0;
        r_busy  <= 1'b1;
      end else if (w_adv) begin
        r_state <= S_SHOW;
        r_index <= w_next_index;
        r_dcnt  <= '0;
        r_gcnt  <= '0;
        r_blank <= 1'b0;
      end else if (w_fin) begin
        r_state <= S_IDLE;
        r_index <= 4'd0;
        r_dcnt  <= '0;
        r_gcnt  <= '0;
        r_blank <= 1'b1;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end else if (w_to_gap) begin
        r_state <= S_GAP;
        r_gcnt  <= GAP_W'(1);
        r_blank <= 1'b1;
      end else if (w_dinc) begin
        r_dcnt <= r_dcnt + DWELL_W'(1);
      end else if (w_ginc) begin
        r_gcnt <= r_gcnt + GAP_W'(1);
      end
    end
  end

  assign code  = r_mem[r_index];
  assign index = r_index;
  assign blank = r_blank;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_seg7_msg_sequencer.sv
// tb/tb_seg7_msg_sequencer.sv - self-checking bench for seg7_msg_sequencer
// using an expected-trace model built from glyph/dwell/gap rules.
module tb_seg7_msg_sequencer;

  localparam int DW = 24;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [3:0]    wr_data;
  logic [3:0]    msg_last;
  logic [DW-1:0] dwell;
  logic [GW-1:0] gap_cyc;
  logic          loop;
  logic          start;
  logic          stop;
  logic          pause;
  logic          step;
  logic [3:0]    code;
  logic          blank;
  logic [3:0]    index;
  logic          busy;
  logic          done;

  seg7_msg_sequencer #(.DWELL_W(DW), .GAP_W(GW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_last(msg_last), .dwell(dwell), .gap_cyc(gap_cyc), .loop(loop),
    .start(start), .stop(stop), .pause(pause), .step(step),
    .code(code), .blank(blank), .index(index), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int last;
    int d;
    int g;
    int exp_cyc;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  mdl_mem [16];
  logic [10:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [10:0] ent(input logic b, input logic [3:0] c,
                                      input logic [3:0] i, input logic bz, input logic dn);
    return {b, c, i, bz, dn};
  endfunction

  task automatic mem_write(input int a, input int v);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = 4'(v);
    tick();
    wr_en = 1'b0;
    mdl_mem[a] = 4'(v);
  endtask

  // Expected per-cycle view of a run: each glyph for d+1 cycles, then g
  // blank cycles whenever another glyph follows.
  task automatic build(input int last, input int d, input int g, input int lp, input int nper);
    exp_q.delete();
    for (int p = 0; p < nper; p++)
      for (int k = 0; k <= last; k++) begin
        for (int c = 0; c <= d; c++) exp_q.push_back(ent(1'b0, mdl_mem[k], 4'(k), 1'b1, 1'b0));
        if (k < last || lp != 0)
          for (int c = 0; c < g; c++) exp_q.push_back(ent(1'b1, mdl_mem[k], 4'(k), 1'b1, 1'b0));
      end
    if (lp == 0) begin
      exp_q.push_back(ent(1'b1, mdl_mem[0], 4'd0, 1'b0, 1'b1));
      exp_q.push_back(ent(1'b1, mdl_mem[0], 4'd0, 1'b0, 1'b0));
    end
  endtask

  task automatic launch(input int last, input int d, input int g, input int lp);
    msg_last = 4'(last); dwell = DW'(d); gap_cyc = GW'(g); loop = lp[0];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic play(input string nm);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s cyc%0d", nm, i), {21'd0, blank, code, index, busy, done}, {21'd0, exp_q[i]});
      tick();
    end
  endtask

  task automatic load_1235();
    mem_write(0, 1); mem_write(1, 2); mem_write(2, 3); mem_write(3, 5);
  endtask

  initial begin
    vec_t vecs[7];
    int   cnt;
    logic seen;
    vecs[0] = '{3, 4, 0, 20};
    vecs[1] = '{3, 4, 2, 26};
    vecs[2] = '{0, 0, 0, 1};
    vecs[3] = '{0, 3, 5, 4};
    vecs[4] = '{1, 0, 1, 3};
    vecs[5] = '{15, 0, 0, 16};
    vecs[6] = '{2, 1, 3, 12};

    reset = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; msg_last = 0; dwell = 0;
    gap_cyc = 0; loop = 0; start = 0; stop = 0; pause = 0; step = 0;
    for (int i = 0; i < 16; i++) mdl_mem[i] = 4'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_state", {27'd0, code, blank}, {27'd0, 4'd0, 1'b1});
    chk("reset_idx_busy_done", {26'd0, index, busy, done}, 32'd0);

    // Basic message, no gap, no loop
    load_1235();
    build(3, 4, 0, 0, 1);
    launch(3, 4, 0, 0);
    play("basic");

    // Table: busy duration and done pulse
    for (int v = 0; v < 7; v++) begin
      launch(vecs[v].last, vecs[v].d, vecs[v].g, 0);
      cnt = 0;
      while (busy === 1'b1 && cnt < 500) begin cnt++; tick(); end
      chk($sformatf("vec%0d busy_cycles", v), cnt, vecs[v].exp_cyc);
      chk($sformatf("vec%0d done_end", v), {29'd0, done, blank, index == 4'd0}, {29'd0, 3'b111});
      tick();
      chk($sformatf("vec%0d done_once", v), {31'd0, done}, 32'd0);
    end

    // Looping with gap: period 28, no done
    build(3, 4, 2, 1, 2);
    launch(3, 4, 2, 1);
    play("loop_gap");
    chk("loop_wrap", {23'd0, blank, index, code}, {23'd0, 1'b0, 4'd0, 4'd1});
    seen = 1'b0;
    for (int i = 0; i < 28; i++) begin seen |= done; tick(); end
    chk("loop_period", {23'd0, blank, index, code}, {23'd0, 1'b0, 4'd0, 4'd1});
    chk("loop_no_done", {31'd0, seen}, 32'd0);
    stop = 1'b1; tick(); stop = 1'b0;

    // Pause mid-dwell, resume, step
    launch(3, 4, 0, 0);
    tick(); tick();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("pause_hold%0d", i), {23'd0, blank, index, code}, {23'd0, 1'b0, 4'd0, 4'd1});
    end
    pause = 1'b0;
    tick(); tick();
    chk("pause_remaining", {28'd0, index}, 32'd0);
    tick();
    chk("pause_resume_adv", {28'd0, index}, 32'd1);
    pause = 1'b1; step = 1'b1; tick(); step = 1'b0;
    chk("step_adv", {24'd0, index, code}, {24'd0, 4'd2, 4'd3});
    tick();
    chk("paused_no_step", {28'd0, index}, 32'd2);
    pause = 1'b0; step = 1'b1; tick(); step = 1'b0;
    chk("step_unpaused_ignored", {28'd0, index}, 32'd2);
    pause = 1'b1; step = 1'b1; tick();
    chk("step_to_last", {28'd0, index}, 32'd3);
    tick(); step = 1'b0; pause = 1'b0;
    chk("step_last_done", {29'd0, done, busy, index == 4'd0}, {29'd0, 3'b101});

    // stop+start same edge, then restart mid-message
    launch(3, 4, 0, 0);
    tick(); tick(); tick();
    stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
    chk("stop_start", {26'd0, busy, done, blank, index}, {26'd0, 3'b001, 4'd0});
    tick();
    chk("stop_no_done", {30'd0, done, busy}, 32'd0);
    launch(3, 4, 0, 0);
    repeat (6) tick();
    chk("pre_restart", {28'd0, index}, 32'd1);
    launch(3, 1, 0, 0);
    chk("restart_idx", {27'd0, blank, index}, {27'd0, 1'b0, 4'd0});
    tick();
    chk("restart_dwell_hold", {28'd0, index}, 32'd0);
    tick();
    chk("restart_dwell_adv", {28'd0, index}, 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;

    // Write current glyph during SHOW
    launch(3, 4, 0, 0);
    tick();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'd9; tick(); wr_en = 1'b0; mdl_mem[0] = 4'd9;
    chk("live_write", {24'd0, index, code}, {24'd0, 4'd0, 4'd9});
    tick(); tick();
    chk("live_write_timing", {28'd0, index}, 32'd0);
    tick();
    chk("live_write_next", {24'd0, index, code}, {24'd0, 4'd1, 4'd2});
    stop = 1'b1; tick(); stop = 1'b0;

    // Randomized runs against the trace model
    for (int r = 0; r < 8; r++) begin
      int last, d, g, lp;
      for (int a = 0; a < 16; a++) mem_write(a, $urandom_range(0, 15));
      last = $urandom_range(0, 15);
      d    = $urandom_range(0, 5);
      g    = $urandom_range(0, 3);
      lp   = $urandom_range(0, 1);
      build(last, d, g, lp, lp + 1);
      launch(last, d, g, lp);
      play($sformatf("rand%0d", r));
      if (lp != 0) begin
        stop = 1'b1; tick(); stop = 1'b0;
        chk($sformatf("rand%0d stop", r), {30'd0, busy, done}, 32'd0);
      end
    end

    // Async reset mid-GAP clears everything
    for (int a = 0; a < 16; a++) mem_write(a, $urandom_range(1, 15));
    launch(3, 1, 2, 1);
    tick(); tick();
    chk("in_gap", {26'd0, blank, busy, index}, {26'd0, 2'b11, 4'd0});
    #2 reset = 1'b1;
    #1;
    chk("async_reset", {21'd0, code, blank, index, busy, done}, {21'd0, 4'd0, 1'b1, 4'd0, 2'b00});
    #1 reset = 1'b0;
    for (int a = 0; a < 16; a++) mdl_mem[a] = 4'd0;
    build(15, 0, 0, 0, 1);
    launch(15, 0, 0, 0);
    play("mem_cleared");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg7_msg_sequencer.md
# seg7_msg_sequencer

Sequences a stored message of glyph codes onto the single seven-segment digit driver. A 16-entry glyph memory is loaded over a simple write port. On command, the block steps through entries 0..last, holding each for a programmable dwell and inserting an optional blanking gap between glyphs. Its `code` output feeds the existing 4-bit glyph decoder, and `blank` forces the digit dark; this replaces the free-running digit counter with a programmable, pausable sequence.

## Interface
- `DWELL_W`, 24: width of dwell count (10 MHz clock, so ≥1 s dwell fits)
- `GAP_W`, 8: width of gap count
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- `wr_en`  in  1  write strobe for glyph memory
- `wr_addr`  in  4  glyph memory address
- `wr_data`  in  4  glyph code to store
- `msg_last`  in  4  index of last glyph in message; sampled on accepted `start`
- `dwell`  in  DWELL_W  dwell count; each glyph shown `dwell`+1 cycles; sampled on `start`
- `gap_cyc`  in  GAP_W  blank cycles between glyphs, 0 = no gap; sampled on `start`
- `loop`  in  1  level; 1 = wrap to index 0 after last glyph, 0 = stop
- `start`  in  1  pulse; begin or restart message at index 0
- `stop`  in  1  pulse; abort to IDLE
- `pause`  in  1  level; freeze sequencing
- `step`  in  1  pulse; manual advance while paused
- `code`  out  4  glyph code, combinational `mem[index]`
- `blank`  out  1  1 = digit must be dark
- `index`  out  4  current message index
- `busy`  out  1  1 when state is not IDLE
- `done`  out  1  one-cycle pulse on normal completion (loop=0)

## Operation
- Glyph memory: 16×4 flops, all cleared to 0 by reset. Write occurs at the `clk` edge with `wr_en`=1. Writes are legal in every state, and a write to the current `index` changes `code` after that edge.
- The sampled `msg_last`, `dwell` and `gap_cyc` are held in registers until the next accepted `start`.
- States:
  - IDLE: `blank`=1, `busy`=0.
  - SHOW: `blank`=0; dwell counter `dcnt` counts 0..`dwell`.
  - GAP: `blank`=1; gap counter `gcnt` counts 1..`gap_cyc`.
- IDLE→SHOW on `start`: `index`←0, `dcnt`←0.
- SHOW, `pause`=0, `dcnt`==`dwell`:
  - If `index`<`msg_last`, or `loop`=1: go to GAP if `gap_cyc`≠0, else stay in SHOW with `index` advanced.
  - Otherwise: go to IDLE, `index`←0, pulse `done`.
- Advance rule: `index`←(`index`==`msg_last`) ? 0 : `index`+1, and `dcnt`←0.
- GAP, `pause`=0, `gcnt`==`gap_cyc`: SHOW with `index` advanced.
- `pause`=1 freezes state, `index`, `dcnt` and `gcnt`; outputs are held.
- `step` is honored only when `pause`=1 in SHOW or GAP. It advances immediately to SHOW with the next index and skips any gap. At the last glyph with `loop`=0 it ends as for normal completion. In all other cases it is ignored.
- `start` in SHOW or GAP restarts at index 0 with newly sampled config.
- Priority on the same edge: `stop` > `start` > `step` > dwell/gap expiry. `stop` → IDLE, `index`←0, no `done`.
- `msg_last`=0 is legal: a one-glyph message that repeats each dwell when looping.
- Reset mid-operation: immediate IDLE, memory cleared, all counters 0.

## Timing
- Reset values: `code`=0, `blank`=1, `index`=0, `busy`=0, `done`=0; config registers 0.
- `start` sampled at edge T gives `blank`=0, `busy`=1, `index`=0 from T+1.
- Each glyph is visible for exactly `dwell`+1 cycles, then `gap_cyc` blank cycles.
- Period of an N-glyph looping message: N·(`dwell`+1+`gap_cyc`).
- `done` is high for exactly the first cycle in IDLE after completion, coincident with `busy`=0.
- `code` is combinational from registered `index` and memory, so it has no extra latency.

## Test plan
- Reset, then write mem[0..3]={1,2,3,5}; `msg_last`=3, `dwell`=4, `gap_cyc`=0, `loop`=0, `start` → `code` sequence 1,2,3,5 with 5 cycles each, then `done` pulses once, `busy`=0, `blank`=1, `index`=0.
- Same message with `gap_cyc`=2, `loop`=1 → each glyph 5 cycles followed by `blank`=1 for 2 cycles; after index 3 it wraps to 0; loop period 28 cycles; no `done`.
- Assert `pause` mid-dwell for 10 cycles → `code` and `index` frozen, dwell resumes with its remaining count. Pulse `step` while paused → next index on the next cycle. `step` with `pause`=0 → ignored.
- `stop` and `start` on the same edge while running → IDLE, `index`=0, no `done`. `start` alone mid-message → `index`=0 next cycle with the new `dwell`.
- Write mem[`index`]=9 during SHOW → `code`=9 the cycle after the write, with dwell timing unchanged.
- Assert `reset` asynchronously mid-GAP → outputs go to reset values without a clock edge, and all memory reads 0 after release.
